fan_pwm_scheduler: RTL and testbench
====================================

FAN_PWM_SCHEDULER -- requirements
Module: fan_pwm_scheduler

Interface
REQ-001 Parameter P_PERIOD_MAX, default 999, last value of the external PWM period counter.
REQ-002 Parameter P_DUTY_LOW, default 300, target duty in LOW.
REQ-003 Parameter P_DUTY_MID, default 600, target duty in MID.
REQ-004 Parameter P_DUTY_HIGH, default 900, target duty in HIGH.
REQ-005 Parameter P_RAMP_STEP, default 100, maximum duty change per PWM period.
REQ-006 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-007 i_reset  input  1  synchronous, active-high reset.
REQ-008 i_btn_up  input  1  single-cycle debounced pulse: speed up.
REQ-009 i_btn_down  input  1  single-cycle debounced pulse: speed down.
REQ-010 i_btn_off  input  1  single-cycle debounced pulse: force OFF.
REQ-011 i_counter  input  10  free-running PWM period count, 0..P_PERIOD_MAX.
REQ-012 o_pwm  output  1  registered fan drive.
REQ-013 o_state  output  2  current mode: OFF=0, LOW=1, MID=2, HIGH=3.
REQ-014 o_duty  output  10  currently applied duty threshold.
REQ-015 o_led  output  4  one-hot mode indicator: OFF=0001, LOW=0010, MID=0100, HIGH=1000.
REQ-016 o_busy  output  1  high while o_duty != target duty of o_state.

Function
REQ-017 Mode FSM SHALL evaluate buttons every cycle with priority: off > (up XOR down); up and down together with off low SHALL leave the mode unchanged.
REQ-018 i_btn_off SHALL move any mode to OFF on the next edge.
REQ-019 i_btn_up SHALL step OFF->LOW->MID->HIGH; up in HIGH SHALL hold HIGH.
REQ-020 i_btn_down SHALL step HIGH->MID->LOW->OFF; down in OFF SHALL hold OFF.
REQ-021 o_state and o_led SHALL change on the same edge as the mode transition (1-cycle latency from button).
REQ-022 Target duty SHALL be 0 / P_DUTY_LOW / P_DUTY_MID / P_DUTY_HIGH for OFF / LOW / MID / HIGH.
REQ-023 A period boundary is a cycle with i_counter == P_PERIOD_MAX; o_duty SHALL update only on the edge ending a boundary cycle, except per REQ-026.
REQ-024 At a boundary, if o_duty < target: o_duty <= min(o_duty + P_RAMP_STEP, target); if o_duty > target: o_duty <= max(o_duty - P_RAMP_STEP, target); equal: hold.
REQ-025 Ramp arithmetic SHALL be computed at 11 bits so o_duty + P_RAMP_STEP cannot wrap; subtraction SHALL clamp at target without underflow.
REQ-026 On an edge where the mode becomes OFF, o_duty SHALL clear to 0 on that same edge regardless of counter position (emergency stop).
REQ-027 A mode change at the same cycle as a boundary SHALL use the new target at that boundary's update.
REQ-028 o_pwm SHALL register (i_counter < o_duty): one-cycle latency; o_duty 0 gives constant 0; o_duty > P_PERIOD_MAX gives constant 1.
REQ-029 o_busy SHALL be combinational from o_duty and the current target.
REQ-030 i_counter values above P_PERIOD_MAX SHALL never count as a boundary and SHALL not corrupt state.

Reset
REQ-031 When i_reset is high at an edge: mode OFF, o_state 0, o_led 0001, o_duty 0, o_pwm 0, o_busy 0; buttons ignored.
REQ-032 Reset asserted mid-ramp SHALL abort the ramp; after release, mode and duty restart from OFF/0.

Verification
REQ-033 Reset, counter cycling 0..999, one up pulse -> o_state 1, o_led 0010 next edge; o_duty 100 after first boundary, 200, 300, then hold; o_busy low from 300.
REQ-034 From LOW settled (300), up pulse at i_counter==999 -> o_state 2 and o_duty 400 on same edge; reaches 600 after two more boundaries.
REQ-035 From HIGH settled (900), off pulse at i_counter==500 -> o_state 0, o_duty 0 next edge; o_pwm 0 one cycle later and thereafter.
REQ-036 up+down same cycle in MID -> no change; up+off same cycle -> OFF; up in HIGH holds HIGH; down in OFF holds OFF.
REQ-037 Duty 300 steady -> o_pwm high exactly for 300 cycles per period (counter values 0..299, observed one cycle later).
REQ-038 Reset asserted for one cycle during MID ramp at o_duty 400 -> all outputs at reset values next edge; no duty change at subsequent boundaries without buttons.

Source files
------------

// File: rtl/fan_pwm_scheduler_if.sv
// Fan PWM scheduler control bus.
//   Buttons   : i_btn_up, i_btn_down, i_btn_off (single-cycle debounced pulses)
//   Counter   : i_counter, the external free-running PWM period count
//   Status    : o_pwm (fan drive), o_state (mode), o_duty (applied duty),
//               o_led (one-hot mode), o_busy (duty still ramping)
// master drives the buttons and the counter; slave is the scheduler.
interface fan_pwm_scheduler_if;
  logic       i_btn_up;
  logic       i_btn_down;
  logic       i_btn_off;
  logic [9:0] i_counter;
  logic       o_pwm;
  logic [1:0] o_state;
  logic [9:0] o_duty;
  logic [3:0] o_led;
  logic       o_busy;

  modport master (
    output i_btn_up, i_btn_down, i_btn_off, i_counter,
    input  o_pwm, o_state, o_duty, o_led, o_busy
  );

  modport slave (
    input  i_btn_up, i_btn_down, i_btn_off, i_counter,
    output o_pwm, o_state, o_duty, o_led, o_busy
  );
endinterface

// File: rtl/fan_pwm_scheduler.sv
// Fan PWM scheduler: a four-mode speed FSM (OFF/LOW/MID/HIGH) driven by
// button pulses, plus a duty ramp that moves the applied duty toward the
// mode's target by at most P_RAMP_STEP per PWM period, and the PWM
// comparator itself.
//   i_clk   : sole clock, rising edge
//   i_reset : synchronous, active-high reset
//   bus     : slave side of fan_pwm_scheduler_if (buttons, counter in;
//             pwm, state, duty, led, busy out)
module fan_pwm_scheduler #(
  parameter int unsigned P_PERIOD_MAX = 999,
  parameter int unsigned P_DUTY_LOW   = 300,
  parameter int unsigned P_DUTY_MID   = 600,
  parameter int unsigned P_DUTY_HIGH  = 900,
  parameter int unsigned P_RAMP_STEP  = 100
) (
  input  logic                i_clk,
  input  logic                i_reset,
  fan_pwm_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_LOW  = 2'd1,
    S_MID  = 2'd2,
    S_HIGH = 2'd3
  } mode_e;

  // Ramp arithmetic is carried at 11 bits so duty + step never wraps.
  localparam logic [10:0] L_STEP   = 11'(P_RAMP_STEP);
  localparam logic [10:0] L_LOW    = 11'(P_DUTY_LOW);
  localparam logic [10:0] L_MID    = 11'(P_DUTY_MID);
  localparam logic [10:0] L_HIGH   = 11'(P_DUTY_HIGH);
  localparam logic [9:0]  L_CNTMAX = 10'(P_PERIOD_MAX);

  mode_e       mode_q, mode_d;
  logic [9:0]  duty_q, duty_d;
  logic [3:0]  led_q, led_d;
  logic        pwm_q;

  logic [10:0] duty_ext;
  logic [10:0] tgt_d;
  logic [10:0] tgt_q;
  logic [10:0] sum;
  logic [10:0] diff;
  logic        boundary;

  function automatic logic [10:0] target_of(input mode_e m);
    logic [10:0] t;
    case (m)
      S_LOW:   t = L_LOW;
      S_MID:   t = L_MID;
      S_HIGH:  t = L_HIGH;
      default: t = '0;
    endcase
    return t;
  endfunction

  always_comb begin
    mode_d = mode_q;
    if (bus.i_btn_off) begin
      mode_d = S_OFF;
    end else if (bus.i_btn_up ^ bus.i_btn_down) begin
      if (bus.i_btn_up) begin
        if (mode_q != S_HIGH) mode_d = mode_e'(mode_q + 2'd1);
      end else begin
        if (mode_q != S_OFF)  mode_d = mode_e'(mode_q - 2'd1);
      end
    end
  end

  // Counter values above the period maximum never match, so they are
  // simply ignored.
  assign boundary = (bus.i_counter == L_CNTMAX);

  // The ramp targets the *next* mode so a mode change landing on a
  // boundary cycle is applied at that same boundary.
  always_comb begin
    duty_ext = {1'b0, duty_q};
    tgt_d    = target_of(mode_d);
    tgt_q    = target_of(mode_q);
    sum      = duty_ext + L_STEP;
    diff     = duty_ext - tgt_d;
    duty_d   = duty_q;
    if (mode_d == S_OFF) begin
      // Emergency stop: clear immediately, independent of counter phase.
      duty_d = '0;
    end else if (boundary) begin
      if (duty_ext < tgt_d) begin
        duty_d = (sum >= tgt_d) ? tgt_d[9:0] : sum[9:0];
      end else if (duty_ext > tgt_d) begin
        duty_d = (diff <= L_STEP) ? tgt_d[9:0] : duty_q - L_STEP[9:0];
      end
    end
    led_d = 4'b0001 << mode_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q <= S_OFF;
      duty_q <= '0;
      led_q  <= 4'b0001;
      pwm_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      duty_q <= duty_d;
      led_q  <= led_d;
      pwm_q  <= (bus.i_counter < duty_q);
    end
  end

  assign bus.o_pwm   = pwm_q;
  assign bus.o_state = mode_q;
  assign bus.o_duty  = duty_q;
  assign bus.o_led   = led_q;
  assign bus.o_busy  = (duty_ext != tgt_q);

endmodule

// File: tb/tb_fan_pwm_scheduler.sv
// Directed bench for fan_pwm_scheduler with default parameters.
module tb_fan_pwm_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  fan_pwm_scheduler_if bus ();

  fan_pwm_scheduler #(
    .P_PERIOD_MAX (999),
    .P_DUTY_LOW   (300),
    .P_DUTY_MID   (600),
    .P_DUTY_HIGH  (900),
    .P_RAMP_STEP  (100)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock: inputs change 1 time unit after the edge, buttons self-clear.
  task automatic step();
    @(posedge clk);
    #1;
    bus.i_btn_up   = 1'b0;
    bus.i_btn_down = 1'b0;
    bus.i_btn_off  = 1'b0;
    cnt = (cnt == 999) ? 0 : cnt + 1;
    bus.i_counter = 10'(cnt);
  endtask

  task automatic run_to(input int unsigned v);
    int unsigned n = 0;
    while (cnt != v && n < 1100) begin
      step();
      n++;
    end
    if (cnt != v) chk("run_to_timeout", cnt, v);
  endtask

  // Advance through the next boundary edge.
  task automatic boundary();
    run_to(999);
    step();
  endtask

  initial begin
    int unsigned highs;
    bus.i_btn_up   = 1'b1;
    bus.i_btn_down = 1'b0;
    bus.i_btn_off  = 1'b0;
    bus.i_counter  = '0;

    // Reset (with a button held, which must be ignored)
    step(); bus.i_btn_up = 1'b1; step(); step();
    chk("rst_state", bus.o_state, 0);
    chk("rst_led",   bus.o_led,   4'b0001);
    chk("rst_duty",  bus.o_duty,  0);
    chk("rst_pwm",   bus.o_pwm,   0);
    chk("rst_busy",  bus.o_busy,  0);
    rst = 1'b0;
    step();

    // OFF -> LOW, ramp 100/200/300
    bus.i_btn_up = 1'b1; step();
    chk("low_state", bus.o_state, 1);
    chk("low_led",   bus.o_led,   4'b0010);
    chk("low_duty0", bus.o_duty,  0);
    chk("low_busy0", bus.o_busy,  1);
    run_to(999);
    chk("low_pre_bnd", bus.o_duty, 0);
    step();
    chk("low_d100", bus.o_duty, 100);
    boundary(); chk("low_d200", bus.o_duty, 200);
    chk("low_busy200", bus.o_busy, 1);
    boundary(); chk("low_d300", bus.o_duty, 300);
    chk("low_busy300", bus.o_busy, 0);
    boundary(); chk("low_hold", bus.o_duty, 300);

    // PWM high for exactly 300 of 1000 cycles
    highs = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      highs += bus.o_pwm;
    end
    chk("pwm_300_count", highs, 300);

    // Up on the boundary cycle uses the new target immediately
    run_to(999);
    bus.i_btn_up = 1'b1; step();
    chk("mid_state", bus.o_state, 2);
    chk("mid_d400",  bus.o_duty,  400);
    boundary(); chk("mid_d500", bus.o_duty, 500);
    boundary(); chk("mid_d600", bus.o_duty, 600);
    chk("mid_busy", bus.o_busy, 0);

    // up+down together in MID: no change
    run_to(100);
    bus.i_btn_up = 1'b1; bus.i_btn_down = 1'b1; step();
    chk("updown_state", bus.o_state, 2);
    chk("updown_led",   bus.o_led,   4'b0100);

    // MID -> HIGH mid-period, ramp to 900, up in HIGH holds
    run_to(500);
    bus.i_btn_up = 1'b1; step();
    chk("high_state", bus.o_state, 3);
    chk("high_led",   bus.o_led,   4'b1000);
    chk("high_nochg", bus.o_duty,  600);
    boundary(); boundary(); boundary();
    chk("high_d900", bus.o_duty, 900);
    bus.i_btn_up = 1'b1; step();
    chk("high_hold", bus.o_state, 3);

    // Down on a boundary: ramp down by one step toward 600
    run_to(999);
    bus.i_btn_down = 1'b1; step();
    chk("down_state", bus.o_state, 2);
    chk("down_d800",  bus.o_duty,  800);
    run_to(999);
    bus.i_btn_up = 1'b1; step();
    chk("back_high_d900", bus.o_duty, 900);

    // Emergency off at counter 500
    run_to(500);
    bus.i_btn_off = 1'b1; step();
    chk("off_state", bus.o_state, 0);
    chk("off_duty",  bus.o_duty,  0);
    chk("off_led",   bus.o_led,   4'b0001);
    chk("off_pwm_lag", bus.o_pwm, 1);
    step();
    chk("off_pwm0", bus.o_pwm, 0);
    boundary();
    chk("off_pwm_later", bus.o_pwm, 0);
    chk("off_duty_later", bus.o_duty, 0);

    // down in OFF holds; up+off -> OFF
    bus.i_btn_down = 1'b1; step();
    chk("down_in_off", bus.o_state, 0);
    bus.i_btn_up = 1'b1; bus.i_btn_off = 1'b1; step();
    chk("up_off", bus.o_state, 0);

    // Reach MID from OFF, ramp to 400
    bus.i_btn_up = 1'b1; step();
    bus.i_btn_up = 1'b1; step();
    chk("mid2_state", bus.o_state, 2);
    boundary(); boundary(); boundary(); boundary();
    chk("mid2_d400", bus.o_duty, 400);

    // Counter above max must not act as a boundary
    @(posedge clk); #1 bus.i_counter = 10'd1023;
    @(posedge clk); #1 bus.i_counter = 10'd1000;
    @(posedge clk); #1 bus.i_counter = 10'(cnt);
    chk("ovr_duty", bus.o_duty, 400);
    chk("ovr_state", bus.o_state, 2);

    // One-cycle reset mid-ramp
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst2_state", bus.o_state, 0);
    chk("rst2_duty",  bus.o_duty,  0);
    chk("rst2_led",   bus.o_led,   4'b0001);
    chk("rst2_pwm",   bus.o_pwm,   0);
    chk("rst2_busy",  bus.o_busy,  0);
    boundary(); boundary();
    chk("rst2_duty_after", bus.o_duty, 0);
    chk("rst2_state_after", bus.o_state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
